// File: rtl/redmule_tiler_q_if.sv
// Job/config bundle between the RedMulE control regfile (master) and the
// GEMM tiler (slave).
//
// Handshakes: both channels are valid/ready. A job transfers on a rising
// clock edge where job_valid && job_ready. A config entry transfers on an
// edge where cfg_valid && cfg_ready. The sender holds valid and its payload
// stable until the transfer. The receiver may drive ready independently of
// valid. err is a single-cycle pulse with no handshake.
interface redmule_tiler_q_if #(
   parameter int DIM_W = 16
) ();

   // job request channel
   logic             job_valid;
   logic             job_ready;
   logic [DIM_W-1:0] m;
   logic [DIM_W-1:0] n;
   logic [DIM_W-1:0] k;
   logic             job_fmt8;
   logic [2:0]       job_op;

   // tiled configuration channel (head of the output queue)
   logic             cfg_valid;
   logic             cfg_ready;
   logic [DIM_W-1:0] x_rows_iter;
   logic [DIM_W-1:0] x_cols_iter;
   logic [DIM_W-1:0] w_rows_iter;
   logic [DIM_W-1:0] w_cols_iter;
   logic [7:0]       x_rows_lftovr;
   logic [7:0]       x_cols_lftovr;
   logic [7:0]       w_rows_lftovr;
   logic [7:0]       w_cols_lftovr;
   logic [DIM_W-1:0] tot_stores;
   logic [31:0]      x_d1_stride;
   logic [31:0]      w_d0_stride;
   logic [31:0]      w_tot_len;
   logic [31:0]      tot_x_read;
   logic [2:0]       cfg_op;
   logic             cfg_fmt8;
   logic             ovf;

   // rejected-job pulse
   logic             err;

   modport master (
      output job_valid, m, n, k, job_fmt8, job_op, cfg_ready,
      input  job_ready, cfg_valid, x_rows_iter, x_cols_iter, w_rows_iter,
             w_cols_iter, x_rows_lftovr, x_cols_lftovr, w_rows_lftovr,
             w_cols_lftovr, tot_stores, x_d1_stride, w_d0_stride, w_tot_len,
             tot_x_read, cfg_op, cfg_fmt8, ovf, err
   );

   modport slave (
      input  job_valid, m, n, k, job_fmt8, job_op, cfg_ready,
      output job_ready, cfg_valid, x_rows_iter, x_cols_iter, w_rows_iter,
             w_cols_iter, x_rows_lftovr, x_cols_lftovr, w_rows_lftovr,
             w_cols_lftovr, tot_stores, x_d1_stride, w_d0_stride, w_tot_len,
             tot_x_read, cfg_op, cfg_fmt8, ovf, err
   );

endinterface

// File: rtl/redmule_tiler_q.sv
// GEMM tiler with an output job queue. One job at a time is tiled: constant
// divides in CALC, then a 16-step shift-add for P = x_rows_iter*w_cols_iter,
// then two parallel 16-step shift-adds for the 48-bit length products. The
// finished entry is pushed into a small circular FIFO whose head drives the
// configuration outputs.
module redmule_tiler_q #(
   parameter int ARRAY_WIDTH  = 12,
   parameter int ARRAY_HEIGHT = 4,
   parameter int PIPE_REGS    = 3,
   parameter int DATAW        = 288,
   parameter int DIM_W        = 16,
   parameter int QUEUE_DEPTH  = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   clear_i,
   redmule_tiler_q_if.slave       bus,
   output logic [2:0]             dbg_state_o
);

   localparam int D      = ARRAY_HEIGHT * (PIPE_REGS + 1);
   localparam int PTR_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1);
   // one multiplier bit per step; DIM_W steps per product
   localparam int STEP_W = $clog2(DIM_W);

   localparam logic [DIM_W-1:0]  AW_C      = DIM_W'(ARRAY_WIDTH);
   localparam logic [DIM_W-1:0]  AH_C      = DIM_W'(ARRAY_HEIGHT);
   localparam logic [DIM_W-1:0]  D_C       = DIM_W'(D);
   localparam logic [31:0]       EPB8_C    = 32'(DATAW / 8);
   localparam logic [31:0]       EPB16_C   = 32'(DATAW / 16);
   localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(QUEUE_DEPTH - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(QUEUE_DEPTH);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DIM_W - 1);

   if (DATAW % 16 != 0) begin : g_chk_dataw
      $error("redmule_tiler_q: DATAW must be a multiple of 16");
   end
   if (ARRAY_WIDTH < 1 || ARRAY_HEIGHT < 1 || PIPE_REGS < 0) begin : g_chk_div
      $error("redmule_tiler_q: tiling divisors must be nonzero");
   end
   if (QUEUE_DEPTH < 1) begin : g_chk_depth
      $error("redmule_tiler_q: QUEUE_DEPTH must be at least 1");
   end

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CALC  = 3'd1,
      MUL1  = 3'd2,
      MUL2  = 3'd3,
      WRITE = 3'd4
   } state_e;

   typedef struct packed {
      logic [DIM_W-1:0] x_rows_iter;
      logic [DIM_W-1:0] x_cols_iter;
      logic [DIM_W-1:0] w_rows_iter;
      logic [DIM_W-1:0] w_cols_iter;
      logic [7:0]       x_rows_lftovr;
      logic [7:0]       x_cols_lftovr;
      logic [7:0]       w_rows_lftovr;
      logic [7:0]       w_cols_lftovr;
      logic [DIM_W-1:0] tot_stores;
      logic [31:0]      x_d1_stride;
      logic [31:0]      w_d0_stride;
      logic [31:0]      w_tot_len;
      logic [31:0]      tot_x_read;
      logic [2:0]       op;
      logic             fmt8;
      logic             ovf;
   } entry_t;

   state_e           state_q;
   logic [DIM_W-1:0] m_q, n_q, k_q;
   logic             fmt8_q;
   logic [2:0]       op_q;
   logic             err_q;
   entry_t           res_q;

   logic [47:0]       mcand_q;
   logic [DIM_W-1:0]  mpa_q, mpb_q;
   logic [31:0]       p_q;
   logic [47:0]       accw_q, accx_q;
   logic [STEP_W-1:0] step_q;

   entry_t            fifo_q [QUEUE_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;

   logic [DIM_W-1:0] c_x_rows_iter, c_x_cols_iter, c_w_rows_iter, c_w_cols_iter;
   logic [31:0]      c_x_base, c_x_rem, c_w_base, c_w_rem;
   logic [31:0]      c_x_d1, c_w_d0;
   logic             c_zero;
   logic [31:0]      p_next;
   entry_t           new_entry;
   entry_t           head;
   logic             full, pop, push;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // Tiling arithmetic on the latched job: constant divides, ceilings and
   // byte strides. w_rows_iter keeps only DIM_W bits, so N near the top of
   // the range rounds up to a wrapped value; ovf does not cover it.
   always_comb begin
      c_zero        = (m_q == '0) || (n_q == '0) || (k_q == '0);
      c_x_rows_iter = m_q / AW_C + DIM_W'(m_q % AW_C != '0);
      c_x_cols_iter = n_q / D_C  + DIM_W'(n_q % D_C  != '0);
      c_w_cols_iter = k_q / D_C  + DIM_W'(k_q % D_C  != '0);
      c_w_rows_iter = (n_q / AH_C + DIM_W'(n_q % AH_C != '0)) * AH_C;
      c_x_base      = 32'(n_q / D_C);
      c_x_rem       = 32'(n_q % D_C);
      c_w_base      = 32'(k_q / D_C);
      c_w_rem       = 32'(k_q % D_C);
      c_x_d1        = fmt8_q ? (c_x_base * EPB8_C + c_x_rem)
                             : ((c_x_base * EPB16_C + c_x_rem) << 1);
      c_w_d0        = fmt8_q ? (c_w_base * EPB8_C + c_w_rem)
                             : ((c_w_base * EPB16_C + c_w_rem) << 1);
   end

   // Next partial product of the P multiplier and the finished queue entry.
   always_comb begin
      p_next               = p_q + (mpa_q[0] ? mcand_q[31:0] : 32'd0);
      new_entry            = res_q;
      new_entry.tot_stores = p_q[DIM_W-1:0];
      new_entry.w_tot_len  = accw_q[31:0];
      new_entry.tot_x_read = accx_q[31:0];
      new_entry.ovf        = (|p_q[31:DIM_W]) | (|accw_q[47:32]) | (|accx_q[47:32]);
   end

   assign full = (count_q == FULL_CNT);
   assign pop  = (count_q != '0) && bus.cfg_ready;
   assign push = (state_q == WRITE) && (!full || pop);
   assign head = (count_q != '0) ? fifo_q[rd_ptr_q] : '0;

   // Tiler FSM, shift-add datapath and output FIFO; clear_i behaves as reset.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         state_q  <= IDLE;
         m_q      <= '0;
         n_q      <= '0;
         k_q      <= '0;
         fmt8_q   <= 1'b0;
         op_q     <= '0;
         err_q    <= 1'b0;
         res_q    <= '0;
         mcand_q  <= '0;
         mpa_q    <= '0;
         mpb_q    <= '0;
         p_q      <= '0;
         accw_q   <= '0;
         accx_q   <= '0;
         step_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < QUEUE_DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         err_q <= 1'b0;

         if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
         if (push) begin
            fifo_q[wr_ptr_q] <= new_entry;
            wr_ptr_q         <= next_ptr(wr_ptr_q);
         end
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;

         case (state_q)
            IDLE: begin
               if (bus.job_valid) begin
                  m_q     <= bus.m;
                  n_q     <= bus.n;
                  k_q     <= bus.k;
                  fmt8_q  <= bus.job_fmt8;
                  op_q    <= bus.job_op;
                  state_q <= CALC;
               end
            end
            CALC: begin
               if (c_zero) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  res_q.x_rows_iter   <= c_x_rows_iter;
                  res_q.x_cols_iter   <= c_x_cols_iter;
                  res_q.w_rows_iter   <= c_w_rows_iter;
                  res_q.w_cols_iter   <= c_w_cols_iter;
                  res_q.x_rows_lftovr <= 8'(m_q % AW_C);
                  res_q.x_cols_lftovr <= 8'(n_q % D_C);
                  res_q.w_rows_lftovr <= 8'(n_q % AH_C);
                  res_q.w_cols_lftovr <= 8'(k_q % D_C);
                  res_q.tot_stores    <= '0;
                  res_q.x_d1_stride   <= c_x_d1;
                  res_q.w_d0_stride   <= c_w_d0;
                  res_q.w_tot_len     <= '0;
                  res_q.tot_x_read    <= '0;
                  res_q.op            <= op_q;
                  res_q.fmt8          <= fmt8_q;
                  res_q.ovf           <= 1'b0;
                  mcand_q             <= 48'(c_x_rows_iter);
                  mpa_q               <= c_w_cols_iter;
                  p_q                 <= '0;
                  step_q              <= '0;
                  state_q             <= MUL1;
               end
            end
            MUL1: begin
               p_q     <= p_next;
               mcand_q <= mcand_q << 1;
               mpa_q   <= mpa_q >> 1;
               step_q  <= step_q + 1'b1;
               if (step_q == LAST_STEP) begin
                  mcand_q <= 48'(p_next);
                  mpa_q   <= res_q.w_rows_iter;
                  mpb_q   <= res_q.x_cols_iter;
                  accw_q  <= '0;
                  accx_q  <= '0;
                  step_q  <= '0;
                  state_q <= MUL2;
               end
            end
            MUL2: begin
               accw_q  <= accw_q + (mpa_q[0] ? mcand_q : 48'd0);
               accx_q  <= accx_q + (mpb_q[0] ? mcand_q : 48'd0);
               mcand_q <= mcand_q << 1;
               mpa_q   <= mpa_q >> 1;
               mpb_q   <= mpb_q >> 1;
               step_q  <= step_q + 1'b1;
               if (step_q == LAST_STEP) state_q <= WRITE;
            end
            WRITE: begin
               if (push) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dbg_state_o       = state_q;
   assign bus.job_ready     = (state_q == IDLE);
   assign bus.err           = err_q;
   assign bus.cfg_valid     = (count_q != '0);
   assign bus.x_rows_iter   = head.x_rows_iter;
   assign bus.x_cols_iter   = head.x_cols_iter;
   assign bus.w_rows_iter   = head.w_rows_iter;
   assign bus.w_cols_iter   = head.w_cols_iter;
   assign bus.x_rows_lftovr = head.x_rows_lftovr;
   assign bus.x_cols_lftovr = head.x_cols_lftovr;
   assign bus.w_rows_lftovr = head.w_rows_lftovr;
   assign bus.w_cols_lftovr = head.w_cols_lftovr;
   assign bus.tot_stores    = head.tot_stores;
   assign bus.x_d1_stride   = head.x_d1_stride;
   assign bus.w_d0_stride   = head.w_d0_stride;
   assign bus.w_tot_len     = head.w_tot_len;
   assign bus.tot_x_read    = head.tot_x_read;
   assign bus.cfg_op        = head.op;
   assign bus.cfg_fmt8      = head.fmt8;
   assign bus.ovf           = head.ovf;

endmodule

// File: tb/tb_redmule_tiler_q.sv
// Bench for redmule_tiler_q: directed timing/flow scenarios plus random jobs.
// Expected entries come from an arithmetic model of the tiling rules and are
// queued at job acceptance; a monitor compares each popped head in order.
module tb_redmule_tiler_q;

   localparam int AW    = 12;
   localparam int AH    = 4;
   localparam int DG    = 16;   // ARRAY_HEIGHT*(PIPE_REGS+1)
   localparam int DATAW = 288;
   localparam int EW    = 245;

   logic       clk;
   logic       rst;
   logic       clear;
   logic [2:0] dbg_state;
   bit         rand_ready;

   int checks    = 0;
   int errors    = 0;
   int err_seen  = 0;
   int exp_err   = 0;

   logic [EW-1:0] exp_q[$];

   redmule_tiler_q_if #(.DIM_W(16)) bus ();

   redmule_tiler_q #(
      .ARRAY_WIDTH(12), .ARRAY_HEIGHT(4), .PIPE_REGS(3),
      .DATAW(288), .DIM_W(16), .QUEUE_DEPTH(2)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .clear_i    (clear),
      .bus        (bus),
      .dbg_state_o(dbg_state)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference tiling from the arithmetic definitions (64-bit integers).
   function automatic logic [EW-1:0] model(input longint unsigned m, input longint unsigned n,
                                           input longint unsigned k, input bit f8,
                                           input logic [2:0] op);
      longint unsigned xr, xc, wr, wc, p, wtl, txr, bytes, epb, xs, ws;
      bit ovf;
      xr    = (m + AW - 1) / AW;
      xc    = (n + DG - 1) / DG;
      wc    = (k + DG - 1) / DG;
      wr    = (((n + AH - 1) / AH) * AH) % 65536;
      bytes = f8 ? 1 : 2;
      epb   = DATAW / (f8 ? 8 : 16);
      xs    = bytes * (epb * (n / DG) + n % DG);
      ws    = bytes * (epb * (k / DG) + k % DG);
      p     = xr * wc;
      wtl   = p * wr;
      txr   = p * xc;
      ovf   = (p > 65535) || (wtl > 64'hFFFF_FFFF) || (txr > 64'hFFFF_FFFF);
      return {16'(xr), 16'(xc), 16'(wr), 16'(wc),
              8'(m % AW), 8'(n % DG), 8'(n % AH), 8'(k % DG),
              16'(p), 32'(xs), 32'(ws), 32'(wtl), 32'(txr), op, f8, ovf};
   endfunction

   function automatic logic [EW-1:0] dut_entry();
      return {bus.x_rows_iter, bus.x_cols_iter, bus.w_rows_iter, bus.w_cols_iter,
              bus.x_rows_lftovr, bus.x_cols_lftovr, bus.w_rows_lftovr, bus.w_cols_lftovr,
              bus.tot_stores, bus.x_d1_stride, bus.w_d0_stride, bus.w_tot_len,
              bus.tot_x_read, bus.cfg_op, bus.cfg_fmt8, bus.ovf};
   endfunction

   // Driver: called 1 time unit after a rising edge; returns 1 time unit
   // after the accepting edge (i.e. inside cycle t+1).
   task automatic send_job(input logic [15:0] m, input logic [15:0] n, input logic [15:0] k,
                           input logic f8, input logic [2:0] op, input bit track);
      int waited = 0;
      bus.job_valid = 1'b1;
      bus.m = m;
      bus.n = n;
      bus.k = k;
      bus.job_fmt8 = f8;
      bus.job_op = op;
      while (!bus.job_ready && waited < 500) begin
         @(posedge clk);
         #1;
         waited++;
      end
      if (!bus.job_ready) begin
         checks++;
         errors++;
         $display("FAIL job_accept_timeout: job_ready got 0 expected 1 within 500 cycles");
         bus.job_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      bus.job_valid = 1'b0;
      if (track) begin
         if (m == 0 || n == 0 || k == 0) exp_err++;
         else exp_q.push_back(model(m, n, k, f8, op));
      end
   endtask

   // Monitor / scoreboard: compare every popped head against the queue.
   always @(negedge clk) begin
      if (!rst && !clear) begin
         if (bus.err) err_seen++;
         if (bus.cfg_valid && bus.cfg_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL cfg_unexpected: got entry %h expected none", dut_entry());
            end else begin
               logic [EW-1:0] e;
               e = exp_q.pop_front();
               check("cfg_entry", 256'(dut_entry()), 256'(e));
            end
         end
      end
   end

   // Random back-pressure on the config channel.
   always @(posedge clk) begin
      #1;
      if (rand_ready) bus.cfg_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      logic [15:0] rm, rn, rk;
      int waited;
      rst = 1'b1;
      clear = 1'b0;
      rand_ready = 1'b0;
      bus.job_valid = 1'b0;
      bus.m = '0;
      bus.n = '0;
      bus.k = '0;
      bus.job_fmt8 = 1'b0;
      bus.job_op = '0;
      bus.cfg_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      check("rst_job_ready", bus.job_ready, 1);
      check("rst_cfg_valid", bus.cfg_valid, 0);
      check("rst_err", bus.err, 0);
      check("rst_outputs_zero", 256'(dut_entry()), 0);

      // 12x12x12 fp16: latency to cfg_valid and back to ready
      bus.cfg_ready = 1'b1;
      send_job(16'd12, 16'd12, 16'd12, 1'b0, 3'd1, 1'b1);
      repeat (33) @(posedge clk);
      #1;
      check("lat_cfg_valid_t34", bus.cfg_valid, 0);
      check("lat_job_ready_t34", bus.job_ready, 0);
      @(posedge clk);
      #1;
      check("lat_cfg_valid_t35", bus.cfg_valid, 1);
      check("lat_job_ready_t35", bus.job_ready, 1);

      // leftover-heavy job in both element formats
      send_job(16'd13, 16'd17, 16'd33, 1'b0, 3'd2, 1'b1);
      send_job(16'd13, 16'd17, 16'd33, 1'b1, 3'd5, 1'b1);

      // zero dimension: error pulse at t+2, nothing queued
      send_job(16'd5, 16'd7, 16'd0, 1'b0, 3'd3, 1'b1);
      check("zero_err_t1", bus.err, 0);
      @(posedge clk);
      #1;
      check("zero_err_t2", bus.err, 1);
      check("zero_ready_t2", bus.job_ready, 1);
      check("zero_cfg_valid_t2", bus.cfg_valid, 0);
      @(posedge clk);
      #1;
      check("zero_err_t3", bus.err, 0);

      // clear mid-job at t+10
      send_job(16'd20, 16'd30, 16'd40, 1'b0, 3'd0, 1'b0);
      repeat (9) @(posedge clk);
      #1 clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      check("clear_job_ready", bus.job_ready, 1);
      check("clear_cfg_valid", bus.cfg_valid, 0);
      repeat (40) @(posedge clk);
      #1;
      check("clear_no_entry", bus.cfg_valid, 0);

      // three jobs with a stalled consumer
      bus.cfg_ready = 1'b0;
      send_job(16'd24, 16'd16, 16'd16, 1'b0, 3'd1, 1'b1);
      send_job(16'd100, 16'd50, 16'd70, 1'b1, 3'd2, 1'b1);
      send_job(16'd7, 16'd3, 16'd1, 1'b0, 3'd4, 1'b1);
      repeat (40) @(posedge clk);
      #1;
      check("full_cfg_valid", bus.cfg_valid, 1);
      check("full_job_ready", bus.job_ready, 0);
      bus.cfg_ready = 1'b1;
      @(posedge clk);
      #1 bus.cfg_ready = 1'b0;
      check("full_pop_push_ready", bus.job_ready, 1);
      check("full_pop_cfg_valid", bus.cfg_valid, 1);
      bus.cfg_ready = 1'b1;

      // overflow corner
      send_job(16'd65535, 16'd65535, 16'd65535, 1'b0, 3'd7, 1'b1);

      // random jobs with random back-pressure
      rand_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         rm = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 65535)) : 16'($urandom_range(1, 64));
         rn = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 65535)) : 16'($urandom_range(1, 64));
         rk = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 65535)) : 16'($urandom_range(1, 64));
         case ($urandom_range(0, 9))
            0: rm = '0;
            1: rk = '0;
            default: ;
         endcase
         send_job(rm, rn, rk, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b1);
      end
      rand_ready = 1'b0;
      bus.cfg_ready = 1'b1;

      // drain
      waited = 0;
      while ((exp_q.size() != 0 || bus.cfg_valid) && waited < 2000) begin
         @(posedge clk);
         #1;
         waited++;
      end
      check("drain_pending", exp_q.size(), 0);
      check("drain_cfg_valid", bus.cfg_valid, 0);
      check("err_pulses", err_seen, exp_err);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
